// File: rtl/serializador_tx.sv
// MSB-first word serializer on reloj_32f; idle frames carry IDLE_SYM so the receiver holds alignment.
// Define SERIAL_PARITY_EN to append an even-parity bit after the LSB of every frame.
module serializador_tx #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC
) (
  input  logic             reloj_32f,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             active_out,
  output logic             byte_done
);

`ifdef SERIAL_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  // Frame image as it sits in the shift register; parity trails the LSB.
  function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SERIAL_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  logic [FRAME-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             active_q, active_d;
  logic             boundary;
  logic             accept;

  always_comb begin
    boundary    = (cnt_q == LAST);
    ready_out   = !hold_full_q || boundary;
    accept      = valid_in && ready_out;
    shift_d     = shift_q << 1;
    cnt_d       = cnt_q + CW'(1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    if (boundary) begin
      cnt_d       = '0;
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        shift_d  = frame_of(hold_q);
        active_d = 1'b1;
      end else begin
        shift_d  = frame_of(IDLE_SYM);
        active_d = 1'b0;
      end
    end
    // Accept after the boundary load so a same-cycle word waits for the next frame.
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge reloj_32f or posedge rst) begin
    if (rst) begin
      shift_q     <= frame_of(IDLE_SYM);
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
    end
  end

  assign data_out   = shift_q[FRAME-1];
  assign active_out = active_q;
  assign byte_done  = active_q && boundary;

endmodule

// File: tb/tb_serializador_tx.sv
// Bench for serializador_tx: frame-level reference model plus word scoreboard, checked every cycle.
module tb_serializador_tx;
  localparam int W = 8;
  localparam logic [7:0] IDLE = 8'hBC;
`ifdef SERIAL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  localparam int LOGN = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, active_out, byte_done;

  always #5 clk = ~clk;

  serializador_tx #(.WIDTH(W), .IDLE_SYM(IDLE)) dut (
    .reloj_32f (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active_out(active_out),
    .byte_done (byte_done)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FL-1:0] frame_bits(input logic [7:0] w);
`ifdef SERIAL_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Reference model: current frame word/kind, position in frame, one pending word.
  int         cyc, pos, n_3c;
  logic [7:0] cur_w, pend_w;
  bit         cur_act, pend, acc_flag;
  logic [7:0] acc_q[$];
  logic [FL-1:0] rx;
  logic       log_d[LOGN], log_a[LOGN], log_b[LOGN];

  always @(negedge clk) begin
    logic [FL-1:0] fb;
    bit exp_rdy, acc;
    if (rst) begin
      chk("reset_data_out", data_out, 1'b1);
      chk("reset_active_out", active_out, 1'b0);
      chk("reset_byte_done", byte_done, 1'b0);
      chk("reset_ready_out", ready_out, 1'b1);
      cyc = 0; pos = 0; cur_w = IDLE; cur_act = 0; pend = 0; acc_flag = 0;
      acc_q.delete();
    end else begin
      fb      = frame_bits(cur_w);
      exp_rdy = !pend || (pos == FL - 1);
      n_vec++;
      chk("data_out", data_out, fb[FL-1-pos]);
      chk("active_out", active_out, cur_act);
      chk("byte_done", byte_done, cur_act && (pos == FL - 1));
      chk("ready_out", ready_out, exp_rdy);
      if (cyc < LOGN) begin
        log_d[cyc] = data_out; log_a[cyc] = active_out; log_b[cyc] = byte_done;
      end
      acc      = valid_in && exp_rdy;
      acc_flag = acc;
      if (cur_act) rx = {rx[FL-2:0], data_out};
      if (pos == FL - 1) begin
        if (cur_act) begin
          if (acc_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_extra: word %0h sent, none accepted", rx[FL-1 -: W]);
          end else begin
            chk("scoreboard_word", rx[FL-1 -: W], acc_q.pop_front());
            if (rx[FL-1 -: W] == 8'h3C) n_3c++;
          end
        end
        cur_act = pend;
        cur_w   = pend ? pend_w : IDLE;
        pend    = 0;
        pos     = 0;
      end else begin
        pos++;
      end
      if (acc) begin
        pend = 1; pend_w = data_in; acc_q.push_back(data_in);
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a word and hold it until the model reports it accepted.
  task automatic send(input logic [7:0] w);
    int budget = 0;
    valid_in = 1'b1; data_in = w;
    do begin tick(); budget++; end while (!acc_flag && budget < 4 * FL);
    if (!acc_flag) begin
      n_fail++;
      $display("FAIL send_timeout: word %0h not accepted in %0d cycles", w, budget);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [FL-1:0]   lit_idle, lit_a5;
  logic [3*FL-1:0] lit3;
  int base, first_act, n3_base;

  initial begin
`ifdef SERIAL_PARITY_EN
    lit_idle = 9'b101111001;
    lit_a5   = 9'b101001010;
    lit3     = 27'b000000011_100000001_111111110;
`else
    lit_idle = 8'b10111100;
    lit_a5   = 8'b10100101;
    lit3     = 24'b00000001_10000000_11111111;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle frame, then 0xA5 accepted at cycle 2 and sent in the second frame.
    tick(); tick();
    send(8'hA5);
    repeat (3 * FL) tick();
    for (int i = 0; i < FL; i++) begin
      chk("lit_idle_bits", log_d[i], lit_idle[FL-1-i]);
      chk("lit_idle_active", log_a[i], 1'b0);
      chk("lit_a5_bits", log_d[FL+i], lit_a5[FL-1-i]);
      chk("lit_a5_active", log_a[FL+i], 1'b1);
      chk("lit_resume_idle", log_d[2*FL+i], lit_idle[FL-1-i]);
    end
    chk("lit_byte_done_last", log_b[2*FL-1], 1'b1);
    chk("lit_byte_done_early", log_b[2*FL-2], 1'b0);
    chk("lit_resume_inactive", log_a[2*FL], 1'b0);

    // Back-to-back words form contiguous active frames.
    base = cyc;
    send(8'h01); send(8'h80); send(8'hFF);
    repeat (4 * FL) tick();
    first_act = -1;
    for (int i = base; i < base + 4 * FL; i++)
      if (first_act < 0 && log_a[i]) first_act = i;
    if (first_act < 0) begin
      n_fail++;
      $display("FAIL contig_start: no active frame after cycle %0d", base);
    end else begin
      for (int i = 0; i < 3 * FL; i++) begin
        chk("contig_bits", log_d[first_act+i], lit3[3*FL-1-i]);
        chk("contig_active", log_a[first_act+i], 1'b1);
      end
    end

    // Word held against backpressure goes out exactly once.
    n3_base = n_3c;
    send(8'h11); send(8'h3C);
    repeat (3 * FL) tick();
    chk("backpressure_3c_frames", n_3c - n3_base, 1);

    // Reset mid-frame with a word held: both the partial frame and the held word vanish.
    send(8'h5A); send(8'hC3);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_data_out", data_out, 1'b1);
    chk("arst_active_out", active_out, 1'b0);
    chk("arst_byte_done", byte_done, 1'b0);
    chk("arst_ready_out", ready_out, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * FL + 1) tick();
    for (int i = 0; i < 2 * FL; i++) begin
      chk("post_reset_idle", log_d[i], lit_idle[FL-1-(i%FL)]);
      chk("post_reset_inactive", log_a[i], 1'b0);
    end

    // Random words with random gaps.
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 2 * FL) : 0) tick();
      send(8'($urandom));
    end
    repeat (3 * FL) tick();
    chk("scoreboard_drain", acc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serializador_tx.md
Name: serializador_tx

Overview:
- Parallel-to-serial transmit stage directly downstream of the clock generator.
- Runs entirely on the fast clock `reloj_32f`. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per cycle.
- Fills idle frames with the comma symbol so the receiver keeps frame alignment.
- One holding register plus one shift register sustain full line rate with no gaps.

Parameters:
- WIDTH, 8, word width and frame length in bits.
- IDLE_SYM, 8'hBC, symbol sent when no word is pending; must be WIDTH bits wide.

Ports:
- reloj_32f  input  1  bit clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  WIDTH  word to transmit.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept data_in this cycle.
- data_out  output  1  serial bit, equal to shift_reg[MSB].
- active_out  output  1  the current frame carries a real word, not IDLE_SYM.
- byte_done  output  1  high during the last bit of an active frame.

Behaviour:
- State:
  - shift_reg: WIDTH bits.
  - bit_cnt: ceil(log2(WIDTH+1)) bits.
  - hold_reg: WIDTH bits, plus a hold_full flag.
  - frame_active flag.
- Reset (async, while rst=1):
  - shift_reg=IDLE_SYM, bit_cnt=0, hold_full=0, frame_active=0.
  - Outputs during reset: data_out=IDLE_SYM[WIDTH-1] (1 for 0xBC), active_out=0, byte_done=0, ready_out=1.
- Cycle 0 is the first rising edge after rst falls. Each frame is WIDTH cycles (bit_cnt 0..WIDTH-1).
- boundary = (bit_cnt==WIDTH-1).
- Not at boundary: shift_reg shifts left by 1, bit_cnt increments.
- At boundary: bit_cnt returns to 0.
  - If hold_full: shift_reg<=hold_reg, frame_active<=1.
  - Otherwise: shift_reg<=IDLE_SYM, frame_active<=0.
- Handshake:
  - ready_out = !hold_full | boundary.
  - Accept = valid_in & ready_out; writes hold_reg and sets hold_full.
  - A boundary load clears hold_full unless an accept happens in the same cycle; if both occur, hold_full stays 1 with the new word.
  - No bypass: a word accepted on a boundary cycle is sent in the following frame, not the current one.
- Latency: a word accepted in frame N is transmitted in frame N+1. Example: accepted at cycle 2 → its bits appear on cycles 8..15.
- Combinational outputs: active_out = frame_active; byte_done = frame_active & boundary.
- Backpressure: while ready_out=0, data_in is ignored. Upstream holds the word; there is no loss and no duplication.
- Reset mid-frame: the partial frame is discarded and any held word is dropped. After release, framing restarts at bit_cnt=0 with an idle frame.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; the extra bit is even parity (XOR of the word), sent after the LSB.
  - IDLE_SYM frames also carry parity.
  - boundary becomes bit_cnt==WIDTH; byte_done fires on the parity bit.
- Undefined: frame is WIDTH bits with no parity logic.

Test Plan:
- Idle after reset, valid_in=0 → data_out repeats 1,0,1,1,1,1,0,0 every 8 cycles from cycle 0; active_out=0; ready_out=1.
- 0xA5 presented at cycle 2 → accepted at cycle 2; cycles 8..15 give 1,0,1,0,0,1,0,1; active_out=1 on cycles 8..15; byte_done=1 only on cycle 15; idle 0xBC resumes at cycle 16.
- valid_in held with 0x01, 0x80, 0xFF, next word presented only after each accept → three contiguous active frames with no idle gap. ready_out drops after the first accept and rises only on boundary cycles. Serial stream: 00000001 10000000 11111111.
- Backpressure: valid_in held with 0x3C while hold_full → exactly one 0x3C frame sent; no repeat.
- Async reset: rst pulsed mid-frame (cycle 11 of an active frame, between edges) → outputs go to reset values immediately; after release, the next frame is 0xBC with active_out=0 and the held word is dropped.
- SERIAL_PARITY_EN defined:
  - 0xA5 → 9 bits: 1,0,1,0,0,1,0,1,0.
  - Idle → 1,0,1,1,1,1,0,0,1 (0xBC has five ones, so parity bit is 1).
  - byte_done is asserted on the 9th bit.
